conv1d_stream_par: RTL

- Parametrised streaming 1-D valid convolution layer with P parallel MAC lanes.
- Successor to the fixed per-layer conv blocks. The filter is loaded at runtime over its own stream port instead of being held in a hard-coded ROM.
- Results saturate to WIDTH instead of wrapping. Partial last groups (SIZE not a multiple of P) are handled.
- Sits between layer streams in the network pipeline: x stream in, y stream out.

---
 rtl/conv1d_stream_par_if.sv | 28 ++
 rtl/conv1d_stream_par.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_stream_par_if.sv
// Stream bundle for conv1d_stream_par: x sample input, filter coefficient
// input and y result output, each with a valid/ready handshake.
//   slave  : the convolution block side (consumes x/f, produces y)
//   master : the upstream/downstream side (produces x/f, consumes y)
// WIDTH must match the WIDTH of the connected conv1d_stream_par.
interface conv1d_stream_par_if #(
    parameter int WIDTH = 16
) ();
    logic signed [WIDTH-1:0] s_data_in_x;
    logic                    s_valid_x;
    logic                    s_ready_x;
    logic signed [WIDTH-1:0] s_data_in_f;
    logic                    s_valid_f;
    logic                    s_ready_f;
    logic signed [WIDTH-1:0] m_data_out_y;
    logic                    m_valid_y;
    logic                    m_ready_y;

    modport slave (
        input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
        output s_ready_x, s_ready_f, m_data_out_y, m_valid_y
    );

    modport master (
        output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, m_ready_y,
        input  s_ready_x, s_ready_f, m_data_out_y, m_valid_y
    );
endinterface

// File: rtl/conv1d_stream_par.sv
// Streaming 1-D valid convolution with P parallel MAC lanes.
// Loads LENX samples (and, once after reset, LENF coefficients), computes
// SIZE = LENX-LENF+1 saturated outputs in groups of P, then streams them out.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - conv1d_stream_par_if.slave: x/f stream inputs, y stream output
// Optional: define CONV1D_STREAM_PAR_RELU_EN to clamp negative results to 0.
module conv1d_stream_par #(
    parameter int WIDTH = 16,
    parameter int LENX  = 24,
    parameter int LENF  = 10,
    parameter int P     = 5
) (
    input  logic clk,
    input  logic reset,
    conv1d_stream_par_if.slave bus
);
    localparam int SIZE = LENX - LENF + 1;
    localparam int ACCW = 2*WIDTH + $clog2(LENF);
    localparam int NG   = (SIZE + P - 1) / P;
    localparam int XAW  = (LENX > 1) ? $clog2(LENX) : 1;
    localparam int XCW  = $clog2(LENX + 1);
    localparam int FAW  = $clog2(LENF);
    localparam int FCW  = $clog2(LENF + 1);
    localparam int YAW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CW   = $clog2(LENF + 3);
    localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
    localparam int IW   = $clog2(LENX + P + 1);

    localparam logic [XCW-1:0] X_END   = XCW'(LENX);
    localparam logic [XCW-1:0] X_LAST  = XCW'(LENX - 1);
    localparam logic [FCW-1:0] F_END   = FCW'(LENF);
    localparam logic [FCW-1:0] F_LAST  = FCW'(LENF - 1);
    localparam logic [CW-1:0]  C_ISSUE = CW'(LENF);
    localparam logic [CW-1:0]  C_ACC   = CW'(LENF + 1);
    localparam logic [CW-1:0]  C_LAST  = CW'(LENF + 2);
    localparam logic [GW-1:0]  G_LAST  = GW'(NG - 1);
    localparam logic [YAW-1:0] Y_LAST  = YAW'(SIZE - 1);
    localparam logic [IW-1:0]  I_LENX  = IW'(LENX);
    localparam logic [IW-1:0]  I_SIZE  = IW'(SIZE);
    localparam logic [IW-1:0]  I_P     = IW'(P);

    localparam logic signed [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACCW-1:0]  ACC_HI = ACCW'(SAT_HI);
    localparam logic signed [ACCW-1:0]  ACC_LO = ACCW'(SAT_LO);

    typedef enum logic [1:0] {LOAD, CONV, OUT} state_t;

    state_t                  state;
    logic [XCW-1:0]          x_cnt;
    logic [FCW-1:0]          f_cnt;
    logic                    f_loaded;
    logic                    ready_x, ready_f, valid_y;
    logic signed [WIDTH-1:0] data_y;
    logic [CW-1:0]           cyc;
    logic [GW-1:0]           grp;
    logic [IW-1:0]           base;
    logic [YAW-1:0]          out_idx;

    logic signed [WIDTH-1:0]   x_mem [LENX];
    logic signed [WIDTH-1:0]   f_mem [LENF];
    logic signed [WIDTH-1:0]   y_mem [SIZE];
    logic signed [WIDTH-1:0]   x_rd  [P];
    logic signed [WIDTH-1:0]   f_rd;
    logic signed [ACCW-1:0]    acc   [P];
    logic signed [2*WIDTH-1:0] prod  [P];
    logic signed [WIDTH-1:0]   sat_y [P];
    logic [IW-1:0]             rd_idx [P];
    logic [IW-1:0]             wr_idx [P];
    logic [CW-1:0]             tap;
    logic x_we, f_we, conv_clear, conv_issue, conv_acc, conv_write;

    assign bus.s_ready_x    = ready_x;
    assign bus.s_ready_f    = ready_f;
    assign bus.m_valid_y    = valid_y;
    assign bus.m_data_out_y = data_y;

    // Group schedule (cyc): 0 clear, 1..LENF issue tap cyc-1,
    // 2..LENF+1 accumulate the tap read one cycle earlier, LENF+2 write.
    always_comb begin
        x_we       = (state == LOAD) && ready_x && bus.s_valid_x;
        f_we       = (state == LOAD) && ready_f && bus.s_valid_f;
        conv_clear = (state == CONV) && (cyc == '0);
        conv_issue = (state == CONV) && (cyc != '0) && (cyc <= C_ISSUE);
        conv_acc   = (state == CONV) && (cyc >= CW'(2)) && (cyc <= C_ACC);
        conv_write = (state == CONV) && (cyc == C_LAST);
        tap        = cyc - CW'(1);
        for (int unsigned k = 0; k < P; k++) begin
            rd_idx[k] = base + IW'(k) + IW'(tap);
            wr_idx[k] = base + IW'(k);
            // Sign-extended operands; the low 2*WIDTH bits are the exact product.
            prod[k]   = {{WIDTH{x_rd[k][WIDTH-1]}}, x_rd[k]} * {{WIDTH{f_rd[WIDTH-1]}}, f_rd};
            if (acc[k] > ACC_HI)
                sat_y[k] = SAT_HI;
            else if (acc[k] < ACC_LO)
                sat_y[k] = SAT_LO;
            else
                sat_y[k] = acc[k][WIDTH-1:0];
`ifdef CONV1D_STREAM_PAR_RELU_EN
            if (sat_y[k][WIDTH-1])
                sat_y[k] = '0;
`else
`endif
        end
    end

    // Storage and MAC datapath; every location is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (x_we)
            x_mem[x_cnt[XAW-1:0]] <= bus.s_data_in_x;
        if (f_we)
            f_mem[f_cnt[FAW-1:0]] <= bus.s_data_in_f;
        if (conv_issue) begin
            f_rd <= f_mem[tap[FAW-1:0]];
            for (int unsigned k = 0; k < P; k++)
                // Lanes past the end of x (only in a partial last group) read zero.
                x_rd[k] <= (rd_idx[k] < I_LENX) ? x_mem[rd_idx[k][XAW-1:0]] : '0;
        end
        for (int unsigned k = 0; k < P; k++) begin
            if (conv_clear)
                acc[k] <= '0;
            else if (conv_acc)
                acc[k] <= acc[k] + ACCW'(prod[k]);
        end
        if (conv_write) begin
            for (int unsigned k = 0; k < P; k++)
                if (wr_idx[k] < I_SIZE)
                    y_mem[wr_idx[k][YAW-1:0]] <= sat_y[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LOAD;
            x_cnt    <= '0;
            f_cnt    <= '0;
            f_loaded <= 1'b0;
            ready_x  <= 1'b0;
            ready_f  <= 1'b0;
            cyc      <= '0;
            grp      <= '0;
            base     <= '0;
            out_idx  <= '0;
            valid_y  <= 1'b0;
            data_y   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (x_we)
                        x_cnt <= x_cnt + XCW'(1);
                    if (f_we)
                        f_cnt <= f_cnt + FCW'(1);
                    if (x_cnt == X_END && (f_loaded || f_cnt == F_END)) begin
                        state    <= CONV;
                        f_loaded <= 1'b1;
                        ready_x  <= 1'b0;
                        ready_f  <= 1'b0;
                        cyc      <= '0;
                        grp      <= '0;
                        base     <= '0;
                    end else begin
                        // Ready drops on the edge that stores the last word.
                        ready_x <= !(x_cnt == X_END || (x_we && x_cnt == X_LAST));
                        ready_f <= !(f_loaded || f_cnt == F_END || (f_we && f_cnt == F_LAST));
                    end
                end
                CONV: begin
                    if (cyc == C_LAST) begin
                        cyc <= '0;
                        if (grp == G_LAST) begin
                            state   <= OUT;
                            out_idx <= '0;
                        end else begin
                            grp  <= grp + GW'(1);
                            base <= base + I_P;
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                OUT: begin
                    if (!valid_y) begin
                        data_y  <= y_mem[out_idx];
                        valid_y <= 1'b1;
                    end else if (bus.m_ready_y) begin
                        if (out_idx == Y_LAST) begin
                            valid_y <= 1'b0;
                            state   <= LOAD;
                            x_cnt   <= '0;
                        end else begin
                            out_idx <= out_idx + YAW'(1);
                            data_y  <= y_mem[out_idx + YAW'(1)];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
